// File: rtl/multiport_register_file.sv
// Multi-port register file with a pending-write scoreboard; r0 reads as zero.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module multiport_register_file #(
  parameter  int REG_SIZE  = 32,
  parameter  int FILE_SIZE = 32,
  parameter  int NUM_READ  = 2,
  parameter  int NUM_WRITE = 1,
  localparam int AW        = $clog2(FILE_SIZE)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_READ-1:0][AW-1:0]        readRegister,
  output logic [NUM_READ-1:0][REG_SIZE-1:0]  readData,
  output logic [NUM_READ-1:0]                readReady,
  input  logic [NUM_WRITE-1:0]               writeEnable,
  input  logic [NUM_WRITE-1:0][AW-1:0]       writeRegister,
  input  logic [NUM_WRITE-1:0][REG_SIZE-1:0] writeData,
  input  logic                               reserveEnable,
  input  logic [AW-1:0]                      reserveRegister,
  output logic [FILE_SIZE-1:0]               pendingMask
);

  logic [REG_SIZE-1:0]  regs_q [FILE_SIZE];
  logic [REG_SIZE-1:0]  regs_d [FILE_SIZE];
  logic [FILE_SIZE-1:0] pend_q;
  logic [FILE_SIZE-1:0] pend_d;
  logic [FILE_SIZE-1:0] wr_hit;
  logic [REG_SIZE-1:0]  wr_val [FILE_SIZE];
  logic [FILE_SIZE-1:0] rsv_hit;

  // Later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    for (int i = 0; i < FILE_SIZE; i++) begin
      wr_hit[i]  = 1'b0;
      wr_val[i]  = '0;
      rsv_hit[i] = 1'b0;
      if (i != 0) begin
        rsv_hit[i] = reserveEnable &&
                     (reserveRegister == AW'(i));
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (writeEnable[w] &&
              (writeRegister[w] == AW'(i))) begin
            wr_hit[i] = 1'b1;
            wr_val[i] = writeData[w];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < FILE_SIZE; i++) begin
      regs_d[i] = wr_hit[i] ? wr_val[i] : regs_q[i];
      pend_d[i] = rsv_hit[i] | (pend_q[i] & ~wr_hit[i]);
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FILE_SIZE; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < FILE_SIZE; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  assign pendingMask = pend_q;

  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      readData[p]  = regs_q[readRegister[p]];
      readReady[p] = ~pend_q[readRegister[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit[readRegister[p]]) begin
        readData[p]  = wr_val[readRegister[p]];
        readReady[p] = ~rsv_hit[readRegister[p]];
      end
`endif
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file: directed scenarios
// followed by a randomized run against an operation-level reference model.
module tb_multiport_register_file;

  localparam int RS = 32;
  localparam int FS = 16;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int AW = $clog2(FS);

  logic                   clk;
  logic                   reset;
  logic [NR-1:0][AW-1:0]  rreg;
  logic [NR-1:0][RS-1:0]  rdata;
  logic [NR-1:0]          rrdy;
  logic [NW-1:0]          we;
  logic [NW-1:0][AW-1:0]  wreg;
  logic [NW-1:0][RS-1:0]  wdata;
  logic                   resv_en;
  logic [AW-1:0]          resv_reg;
  logic [FS-1:0]          pmask;

  int nvec = 0;
  int nerr = 0;

  multiport_register_file #(
    .REG_SIZE (RS),
    .FILE_SIZE(FS),
    .NUM_READ (NR),
    .NUM_WRITE(NW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .readRegister   (rreg),
    .readData       (rdata),
    .readReady      (rrdy),
    .writeEnable    (we),
    .writeRegister  (wreg),
    .writeData      (wdata),
    .reserveEnable  (resv_en),
    .reserveRegister(resv_reg),
    .pendingMask    (pmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we       = '0;
    wreg     = '0;
    wdata    = '0;
    resv_en  = 1'b0;
    resv_reg = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rreg  = '0;
    reset = 1'b0;
    rreg[0] = 4'd5;
    rreg[1] = 4'd6;
    #3;
    nvec++;
    if (pmask !== '0) begin
      nerr++;
      $display("FAIL reset_pmask got %h want 0", pmask);
    end
    nvec++;
    if (rrdy !== '1) begin
      nerr++;
      $display("FAIL reset_ready got %b want 111", rrdy);
    end
    nvec++;
    if (rdata[0] !== '0) begin
      nerr++;
      $display("FAIL reset_data got %h want 0", rdata[0]);
    end
    step();
    reset = 1'b1;
    step();
    we[0]    = 1'b1;
    wreg[0]  = 4'd5;
    wdata[0] = 32'hDEAD_BEEF;
    resv_en  = 1'b1;
    resv_reg = 4'd6;
    step();
    idle();
    #1;
    nvec++;
    if (rdata[0] !== 32'hDEAD_BEEF) begin
      nerr++;
      $display("FAIL pre_reset_r5 got %h want deadbeef", rdata[0]);
    end
    nvec++;
    if (pmask !== 16'h0040) begin
      nerr++;
      $display("FAIL pre_reset_pmask got %h want 0040", pmask);
    end
    #1;
    reset = 1'b0;
    #1;
    nvec++;
    if (rdata[0] !== '0) begin
      nerr++;
      $display("FAIL async_reset_r5 got %h want 0", rdata[0]);
    end
    nvec++;
    if (pmask !== '0 || rrdy !== '1) begin
      nerr++;
      $display("FAIL async_reset_sb got %h/%b want 0/111",
               pmask, rrdy);
    end
    we[0]    = 1'b1;
    wreg[0]  = 4'd5;
    wdata[0] = 32'h1234;
    resv_en  = 1'b1;
    resv_reg = 4'd6;
    step();
    nvec++;
    if (rdata[0] !== '0 || pmask !== '0) begin
      nerr++;
      $display("FAIL reset_drop got %h/%h want 0/0",
               rdata[0], pmask);
    end
    idle();
    #1;
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    step();
    we       = 2'b11;
    wreg[0]  = 4'd7;
    wdata[0] = 32'h1234_5678;
    wreg[1]  = 4'd0;
    wdata[1] = 32'hFFFF_FFFF;
    step();
    idle();
    for (int p = 0; p < NR; p++) rreg[p] = 4'd7;
    #1;
    for (int p = 0; p < NR; p++) begin
      nvec++;
      if (rdata[p] !== 32'h1234_5678) begin
        nerr++;
        $display("FAIL wr_rd port%0d got %h want 12345678",
                 p, rdata[p]);
      end
    end
    rreg[0] = 4'd0;
    #1;
    nvec++;
    if (rdata[0] !== '0 || rrdy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL r0_read got %h/%b want 0/1",
               rdata[0], rrdy[0]);
    end
  endtask

  task automatic test_conflict();
    step();
    we       = 2'b11;
    wreg[0]  = 4'd3;
    wdata[0] = 32'hAAAA;
    wreg[1]  = 4'd3;
    wdata[1] = 32'h5555;
    step();
    idle();
    rreg[1] = 4'd3;
    #1;
    nvec++;
    if (rdata[1] !== 32'h5555) begin
      nerr++;
      $display("FAIL conflict got %h want 5555", rdata[1]);
    end
  endtask

  task automatic test_scoreboard();
    step();
    resv_en  = 1'b1;
    resv_reg = 4'd9;
    step();
    idle();
    rreg[0] = 4'd9;
    #1;
    nvec++;
    if (pmask[9] !== 1'b1 || rrdy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reserve got %b/%b want 1/0",
               pmask[9], rrdy[0]);
    end
    we[0]    = 1'b1;
    wreg[0]  = 4'd9;
    wdata[0] = 32'h99;
    step();
    idle();
    #1;
    nvec++;
    if (pmask[9] !== 1'b0 || rrdy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL clear got %b/%b want 0/1",
               pmask[9], rrdy[0]);
    end
    we[1]    = 1'b1;
    wreg[1]  = 4'd9;
    wdata[1] = 32'h77;
    resv_en  = 1'b1;
    resv_reg = 4'd9;
    step();
    idle();
    resv_en  = 1'b1;
    resv_reg = 4'd0;
    step();
    idle();
    #1;
    nvec++;
    if (pmask !== 16'h0200) begin
      nerr++;
      $display("FAIL rsv_wins got %h want 0200", pmask);
    end
    we[0]   = 1'b1;
    wreg[0] = 4'd9;
    step();
    idle();
  endtask

  task automatic test_bypass();
    step();
    we[0]    = 1'b1;
    wreg[0]  = 4'd4;
    wdata[0] = 32'h0001;
    step();
    wdata[0] = 32'hCAFE;
    rreg[2]  = 4'd4;
    #1;
    nvec++;
`ifdef REGFILE_BYPASS_EN
    if (rdata[2] !== 32'hCAFE || rrdy[2] !== 1'b1) begin
      nerr++;
      $display("FAIL bypass got %h/%b want cafe/1",
               rdata[2], rrdy[2]);
    end
`else
    if (rdata[2] !== 32'h0001 || rrdy[2] !== 1'b1) begin
      nerr++;
      $display("FAIL no_bypass got %h/%b want 0001/1",
               rdata[2], rrdy[2]);
    end
`endif
    step();
    idle();
    #1;
    nvec++;
    if (rdata[2] !== 32'hCAFE) begin
      nerr++;
      $display("FAIL bypass_next got %h want cafe", rdata[2]);
    end
    we[0]    = 1'b1;
    wreg[0]  = 4'd4;
    wdata[0] = 32'hBEEF;
    resv_en  = 1'b1;
    resv_reg = 4'd4;
    #1;
    nvec++;
`ifdef REGFILE_BYPASS_EN
    if (rdata[2] !== 32'hBEEF || rrdy[2] !== 1'b0) begin
      nerr++;
      $display("FAIL bypass_rsv got %h/%b want beef/0",
               rdata[2], rrdy[2]);
    end
`else
    if (rdata[2] !== 32'hCAFE || rrdy[2] !== 1'b1) begin
      nerr++;
      $display("FAIL nobyp_rsv got %h/%b want cafe/1",
               rdata[2], rrdy[2]);
    end
`endif
    step();
    idle();
    we[0]   = 1'b1;
    wreg[0] = 4'd4;
    step();
    idle();
  endtask

  task automatic test_random();
    logic [RS-1:0] mem [FS];
    logic [FS-1:0] pend;
    logic [RS-1:0] exp_d;
    logic          exp_r;
    int            idx;
    #1;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < FS; i++) mem[i] = '0;
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int w = 0; w < NW; w++) begin
        we[w]    = ($urandom_range(0, 1) == 1);
        wreg[w]  = AW'($urandom_range(0, FS - 1));
        wdata[w] = $urandom;
      end
      resv_en  = ($urandom_range(0, 2) == 0);
      resv_reg = AW'($urandom_range(0, FS - 1));
      for (int p = 0; p < NR; p++)
        rreg[p] = AW'($urandom_range(0, FS - 1));
      #1;
      for (int p = 0; p < NR; p++) begin
        idx   = int'(rreg[p]);
        exp_d = mem[idx];
        exp_r = !pend[idx];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NW; w++) begin
          if (we[w] && int'(wreg[w]) == idx && idx != 0) begin
            exp_d = wdata[w];
            exp_r = !(resv_en && int'(resv_reg) == idx);
          end
        end
`endif
        nvec++;
        if (rdata[p] !== exp_d || rrdy[p] !== exp_r) begin
          nerr++;
          $display("FAIL rand c%0d p%0d r%0d got %h/%b want %h/%b",
                   c, p, idx, rdata[p], rrdy[p], exp_d, exp_r);
        end
      end
      nvec++;
      if (pmask !== pend) begin
        nerr++;
        $display("FAIL rand_pmask c%0d got %h want %h",
                 c, pmask, pend);
      end
      for (int w = 0; w < NW; w++) begin
        if (we[w] && wreg[w] != 0) begin
          mem[wreg[w]]  = wdata[w];
          pend[wreg[w]] = 1'b0;
        end
      end
      if (resv_en && resv_reg != 0) pend[resv_reg] = 1'b1;
    end
    step();
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_scoreboard();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
